// File: rtl/otfs_pkg.sv
// otfs_pkg -- shared constants and types for the OTFS FFT feed path.
//
// Contents:
//   LOG2N_DEF    : default log2 of FFT length / delay-Doppler grid side
//   N, FRAME_LEN : grid side and samples per frame for the default size
//   CFG_FWD_DEF  : FFT config word selecting a forward transform
//   CFG_INV_DEF  : FFT config word selecting an inverse transform
//   SKID_DEPTH   : entries in the output skid buffer
//   feed_state_t : feed controller state encoding
package otfs_pkg;

  localparam int LOG2N_DEF = 6;
  localparam int N         = 1 << LOG2N_DEF;
  localparam int FRAME_LEN = N * N;

  localparam logic [7:0] CFG_FWD_DEF = 8'h01;
  localparam logic [7:0] CFG_INV_DEF = 8'h00;

  localparam int SKID_DEPTH = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CFG    = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } feed_state_t;

endpackage

// File: rtl/otfs_feed_skid.sv
// otfs_feed_skid -- 2-entry skid buffer between the frame-buffer read path
// and the AXI-Stream data output.  The head entry is presented on pop_data
// straight from a register, so the output is stable while the consumer stalls.
//
// Ports:
//   Clk       in   clock, rising edge
//   Srst      in   synchronous active-high reset, empties the buffer
//   push      in   write push_data (one RAM word returned this cycle)
//   push_data in   W-bit entry
//   pop       in   remove the head entry (AXI handshake)
//   pop_data  out  head entry (meaningful only when empty=0)
//   full      out  both entries occupied
//   empty     out  no entry occupied
module otfs_feed_skid
  import otfs_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         Clk,
  input  logic         Srst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;
  logic                  pop_ok;
  logic                  push_ok;
  logic [SKID_DEPTH-1:0] wr_sel;

  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'd2);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the head slot, so a push into a full
  // buffer is still safe when it coincides with a pop.
  assign push_ok = push & (~full | pop_ok);
  assign wr_sel  = push_ok ? (wr_ptr_reg ? 2'b10 : 2'b01) : 2'b00;

  for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
    logic [W-1:0] data_reg;
    always_ff @(posedge Clk) begin
      if (Srst) begin
        data_reg <= '0;
      end else if (wr_sel[gi]) begin
        data_reg <= push_data;
      end
    end
  end

  assign pop_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;

  always_ff @(posedge Clk) begin
    if (Srst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg ^ push_ok;
      rd_ptr_reg <= rd_ptr_reg ^ pop_ok;
      count_reg  <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/otfs_fft_feed_ctrl.sv
// otfs_fft_feed_ctrl -- streams one delay-Doppler frame from the frame buffer
// into an AXI-Stream FFT core, column by column, after sending the FFT
// direction on the config channel.
//
// Optional feature: define OTFS_FEED_ERRCNT_EN to add the saturating
// FFT-event counters ErrUnexp / ErrMiss.
//
// Ports:
//   Clk, Srst                 clock (rising edge), synchronous active-high reset
//   Start, FftFwd             one-cycle frame request, direction (1=forward)
//   Busy, Done                frame in progress, one-cycle completion pulse
//   RamRdEn, RamAddr, RamDout frame-buffer read port, data 1 cycle after RamRdEn
//   CfgTdata/Tvalid/Tready    FFT config channel
//   DataTdata/Tvalid/Tlast/Tready  FFT input stream, one FFT per column
//   EvTlastUnexp, EvTlastMiss FFT event strobes
//   ErrUnexp, ErrMiss         (OTFS_FEED_ERRCNT_EN only) saturating event counts
module otfs_fft_feed_ctrl
  import otfs_pkg::*;
#(
  parameter int         LOG2N   = LOG2N_DEF,
  parameter logic [7:0] CFG_FWD = CFG_FWD_DEF,
  parameter logic [7:0] CFG_INV = CFG_INV_DEF
) (
  input  logic               Clk,
  input  logic               Srst,
  input  logic               Start,
  input  logic               FftFwd,
  output logic               Busy,
  output logic               Done,
  output logic               RamRdEn,
  output logic [2*LOG2N-1:0] RamAddr,
  input  logic [31:0]        RamDout,
  output logic [7:0]         CfgTdata,
  output logic               CfgTvalid,
  input  logic               CfgTready,
  output logic [31:0]        DataTdata,
  output logic               DataTvalid,
  output logic               DataTlast,
  input  logic               DataTready,
  input  logic               EvTlastUnexp,
  input  logic               EvTlastMiss
`ifdef OTFS_FEED_ERRCNT_EN
  ,
  output logic [7:0]         ErrUnexp,
  output logic [7:0]         ErrMiss
`endif
);

  localparam int AW = 2 * LOG2N;

  feed_state_t   state_reg;
  feed_state_t   state_next;
  logic          fwd_reg;
  logic [AW-1:0] rd_idx_reg;
  logic [AW-1:0] beat_reg;
  logic          inflight_reg;

  logic          start_ok;
  logic          cfg_hs;
  logic          rd_window;
  logic          rd_issue;
  logic          beat_hs;
  logic [1:0]    occupancy;
  logic          skid_full;
  logic          skid_empty;
  logic [31:0]   skid_din;
  logic [31:0]   skid_dout;
  logic          unused_bits;

  assign start_ok = (state_reg == ST_IDLE) & Start;
  assign cfg_hs   = (state_reg == ST_CFG) & CfgTready;
  assign beat_hs  = ~skid_empty & DataTready;

  // Read 0 is issued in the config handshake cycle itself so the first beat
  // is presented two cycles after the handshake.
  assign rd_window = cfg_hs | (state_reg == ST_STREAM);

  // Credit check: entries held + read in flight - beat leaving now < 2.
  // Written as a sum on both sides so nothing underflows.
  assign occupancy = {skid_full, ~skid_full & ~skid_empty};
  assign rd_issue  = rd_window &
                     (({1'b0, occupancy} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, beat_hs}));

  assign RamRdEn = rd_issue;
  // Column-major walk: low index bits select the row (stride N), high bits the column.
  assign RamAddr = {rd_idx_reg[LOG2N-1:0], rd_idx_reg[AW-1:LOG2N]};

  // Keep the 12 significant bits of each 16-bit component and sign-extend.
  assign skid_din = {{4{RamDout[29]}}, RamDout[29:18], {4{RamDout[13]}}, RamDout[13:2]};

  otfs_feed_skid #(
    .W(32)
  ) u_skid (
    .Clk       (Clk),
    .Srst      (Srst),
    .push      (inflight_reg),
    .push_data (skid_din),
    .pop       (beat_hs),
    .pop_data  (skid_dout),
    .full      (skid_full),
    .empty     (skid_empty)
  );

  assign DataTvalid = ~skid_empty;
  assign DataTdata  = DataTvalid ? skid_dout : 32'h0;
  // beat_reg only moves on a handshake, so Tlast is stable while stalled.
  assign DataTlast  = DataTvalid & (beat_reg[LOG2N-1:0] == '1);

  always_ff @(posedge Clk) begin
    if (Srst) begin
      state_reg    <= ST_IDLE;
      fwd_reg      <= 1'b0;
      rd_idx_reg   <= '0;
      beat_reg     <= '0;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= rd_issue;
      if (start_ok) begin
        fwd_reg    <= FftFwd;
        rd_idx_reg <= '0;
        beat_reg   <= '0;
      end else begin
        if (rd_issue) begin
          rd_idx_reg <= rd_idx_reg + 1'b1;
        end
        if (beat_hs) begin
          beat_reg <= beat_reg + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    Busy       = 1'b1;
    Done       = 1'b0;
    CfgTvalid  = 1'b0;
    CfgTdata   = 8'h00;
    case (state_reg)
      ST_IDLE: begin
        Busy = 1'b0;
        if (Start) begin
          state_next = ST_CFG;
        end
      end
      ST_CFG: begin
        CfgTvalid = 1'b1;
        CfgTdata  = fwd_reg ? CFG_FWD : CFG_INV;
        if (CfgTready) begin
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (rd_issue && (rd_idx_reg == '1)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (beat_hs && (beat_reg == '1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        Done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

`ifdef OTFS_FEED_ERRCNT_EN
  logic [1:0] ev;
  assign ev = {EvTlastMiss, EvTlastUnexp};

  for (genvar gi = 0; gi < 2; gi++) begin : g_err
    logic [7:0] cnt_reg;
    always_ff @(posedge Clk) begin
      if (Srst || start_ok) begin
        cnt_reg <= 8'h00;
      end else if (ev[gi] && (cnt_reg != 8'hFF)) begin
        cnt_reg <= cnt_reg + 8'd1;
      end
    end
  end

  assign ErrUnexp    = g_err[0].cnt_reg;
  assign ErrMiss     = g_err[1].cnt_reg;
  assign unused_bits = ^{RamDout[31:30], RamDout[17:14], RamDout[1:0]};
`else
  assign unused_bits = ^{EvTlastUnexp, EvTlastMiss,
                         RamDout[31:30], RamDout[17:14], RamDout[1:0]};
`endif

endmodule
